// File: rtl/fp_add_sub_arbiter.sv
// Round-robin front end that time-shares one fixed-latency fp_add_sub unit between NUM_REQ
// requesters, with one operation in flight at a time.
module fp_add_sub_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int FP_LATENCY = 3,
    parameter int GNT_W      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_num1,
    input  logic [32*NUM_REQ-1:0]   req_num2,
    input  logic [2*NUM_REQ-1:0]    req_op,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [31:0]             resp_result,
    output logic                    busy,
    output logic [GNT_W-1:0]        gnt_id,
    output logic [31:0]             fpu_num1,
    output logic [31:0]             fpu_num2,
    output logic [1:0]              fpu_op,
    input  logic [31:0]             fpu_result,
    output logic [1:0]              dbg_state
);

    // Handshakes: a request transfers on the rising edge where req_valid[i] & req_ready[i];
    // a response transfers on the edge where resp_valid[i] & resp_ready[i]. Requesters hold
    // valid and payload until accepted; resp_result is held until the response transfers.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int                CNT_W     = (FP_LATENCY > 1) ? $clog2(FP_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(FP_LATENCY - 1);
    localparam logic [GNT_W-1:0]  LAST_INIT = GNT_W'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GNT_W-1:0]   last_grant_q, last_grant_d;
    logic [GNT_W-1:0]   gnt_id_q, gnt_id_d;
    logic [31:0]        num1_q, num1_d;
    logic [31:0]        num2_q, num2_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        result_q, result_d;

    logic               pick_found;
    logic [GNT_W-1:0]   pick_idx;
    logic [GNT_W-1:0]   cand;

    // Search starts one past the last served requester, so it ends up with lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GNT_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i]  = rstn && (state_q == ST_IDLE) && pick_found && (pick_idx == GNT_W'(i));
            resp_valid[i] = (state_q == ST_RESP) && (gnt_id_q == GNT_W'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        num1_d       = num1_q;
        num2_d       = num2_q;
        op_d         = op_q;
        result_d     = result_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == GNT_W'(i)) begin
                            num1_d = req_num1[32*i +: 32];
                            num2_d = req_num2[32*i +: 32];
                            op_d   = req_op[2*i +: 2];
                        end
                    end
                    gnt_id_d = pick_idx;
                    cnt_d    = CNT_INIT;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Operands became stable on the accept edge, so cnt==0 marks the
                // FP_LATENCY-th stable cycle and fpu_result is valid now.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    result_d = fpu_result;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready[gnt_id_q]) begin
                    last_grant_d = gnt_id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= LAST_INIT;
            gnt_id_q     <= '0;
            num1_q       <= '0;
            num2_q       <= '0;
            op_q         <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            num1_q       <= num1_d;
            num2_q       <= num2_d;
            op_q         <= op_d;
            result_q     <= result_d;
        end
    end

    assign resp_result = result_q;
    assign busy        = (state_q != ST_IDLE);
    assign gnt_id      = gnt_id_q;
    assign fpu_num1    = num1_q;
    assign fpu_num2    = num2_q;
    assign fpu_op      = op_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fp_add_sub_arbiter.sv
// Bench for fp_add_sub_arbiter: a 2-requester/latency-3 instance and a 3-requester/latency-1
// instance, each driving a stub FPU, with a result scoreboard per instance.
module tb_fp_add_sub_arbiter;

    localparam logic [31:0] OP_A = 32'h3F8E147B;
    localparam logic [31:0] OP_B = 32'h3F8147AE;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // ---------------- instance A: NUM_REQ=2, FP_LATENCY=3 ----------------
    logic [1:0]  rv_a, rdy_a, rspv_a, rr_a, fop_a, dbg_a;
    logic [63:0] n1_a, n2_a;
    logic [3:0]  op_a;
    logic [31:0] res_a, fn1_a, fn2_a, fres_a, s1_a, s2_a;
    logic        busy_a;
    logic [0:0]  gnt_a;

    fp_add_sub_arbiter #(.NUM_REQ(2), .FP_LATENCY(3)) dut_a (
        .clk(clk), .rstn(rstn),
        .req_valid(rv_a), .req_ready(rdy_a),
        .req_num1(n1_a), .req_num2(n2_a), .req_op(op_a),
        .resp_valid(rspv_a), .resp_ready(rr_a), .resp_result(res_a),
        .busy(busy_a), .gnt_id(gnt_a),
        .fpu_num1(fn1_a), .fpu_num2(fn2_a), .fpu_op(fop_a), .fpu_result(fres_a),
        .dbg_state(dbg_a)
    );

    // ---------------- instance B: NUM_REQ=3, FP_LATENCY=1 ----------------
    logic [2:0]  rv_b, rdy_b, rspv_b, rr_b;
    logic [95:0] n1_b, n2_b;
    logic [5:0]  op_b;
    logic [31:0] res_b, fn1_b, fn2_b, fres_b;
    logic [1:0]  fop_b, gnt_b, dbg_b;
    logic        busy_b;

    fp_add_sub_arbiter #(.NUM_REQ(3), .FP_LATENCY(1)) dut_b (
        .clk(clk), .rstn(rstn),
        .req_valid(rv_b), .req_ready(rdy_b),
        .req_num1(n1_b), .req_num2(n2_b), .req_op(op_b),
        .resp_valid(rspv_b), .resp_ready(rr_b), .resp_result(res_b),
        .busy(busy_b), .gnt_id(gnt_b),
        .fpu_num1(fn1_b), .fpu_num2(fn2_b), .fpu_op(fop_b), .fpu_result(fres_b),
        .dbg_state(dbg_b)
    );

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            default: return 32'h0;
        endcase
    endfunction

    // FPU stubs: result valid FP_LATENCY cycles after the inputs settle.
    always @(posedge clk) begin
        s1_a <= model(fn1_a, fn2_a, fop_a);
        s2_a <= s1_a;
    end
    assign fres_a = s2_a;
    assign fres_b = model(fn1_b, fn2_b, fop_b);

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    logic [33:0] exp_q_a[$];
    logic [33:0] exp_q_b[$];
    logic [33:0] e_a, e_b;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rv_a[i] && rdy_a[i])
                exp_q_a.push_back({2'(i), model(n1_a[32*i +: 32], n2_a[32*i +: 32], op_a[2*i +: 2])});
        end
        for (int i = 0; i < 2; i++) begin
            if (rspv_a[i] && rr_a[i]) begin
                if (exp_q_a.size() == 0) begin
                    check_eq("a_unexpected_resp", 64'(rspv_a), 64'h0);
                end else begin
                    e_a = exp_q_a.pop_front();
                    check_eq("a_sb_id", 64'(i), 64'(e_a[33:32]));
                    check_eq("a_sb_result", 64'(res_a), 64'(e_a[31:0]));
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rv_b[i] && rdy_b[i])
                exp_q_b.push_back({2'(i), model(n1_b[32*i +: 32], n2_b[32*i +: 32], op_b[2*i +: 2])});
        end
        for (int i = 0; i < 3; i++) begin
            if (rspv_b[i] && rr_b[i]) begin
                if (exp_q_b.size() == 0) begin
                    check_eq("b_unexpected_resp", 64'(rspv_b), 64'h0);
                end else begin
                    e_b = exp_q_b.pop_front();
                    check_eq("b_sb_id", 64'(i), 64'(e_b[33:32]));
                    check_eq("b_sb_result", 64'(res_b), 64'(e_b[31:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_a(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        rv_a[id]          = 1'b1;
        n1_a[32*id +: 32] = a;
        n2_a[32*id +: 32] = b;
        op_a[2*id +: 2]   = op;
    endtask

    task automatic drive_b(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        rv_b[id]          = 1'b1;
        n1_b[32*id +: 32] = a;
        n2_b[32*id +: 32] = b;
        op_b[2*id +: 2]   = op;
    endtask

    // Returns the number of cycles valid waited before ready; drops valid after the handshake.
    task automatic accept_a(input int id, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (rdy_a[id]) break;
            cyc++;
        end
        check_eq("a_accept_seen", 64'(rdy_a[id]), 64'h1);
        @(posedge clk); #1;
        rv_a[id] = 1'b0;
    endtask

    task automatic accept_b(input int id, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (rdy_b[id]) break;
            cyc++;
        end
        check_eq("b_accept_seen", 64'(rdy_b[id]), 64'h1);
        @(posedge clk); #1;
        rv_b[id] = 1'b0;
    endtask

    // Called just after the accept edge; returns cycles until resp_valid[id] is seen.
    task automatic resp_wait_a(input int id, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rspv_a[id]) break;
        end
        check_eq("a_resp_seen", 64'(rspv_a[id]), 64'h1);
    endtask

    task automatic resp_wait_b(input int id, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rspv_b[id]) break;
        end
        check_eq("b_resp_seen", 64'(rspv_b[id]), 64'h1);
    endtask

    task automatic idle_a();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy_a) break;
        end
        check_eq("a_back_to_idle", 64'(busy_a), 64'h0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    int          c;
    int          n;
    int          order[4];
    int          tm[4];
    logic        ok;
    logic [31:0] hold;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        rv_a = '0; rr_a = 2'b11; n1_a = '0; n2_a = '0; op_a = '0;
        rv_b = '0; rr_b = 3'b111; n1_b = '0; n2_b = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_handshake_outs", 64'({rdy_a, rspv_a, busy_a}), 64'h0);
        check_eq("rst_state_gnt", 64'({gnt_a, dbg_a}), 64'h0);
        check_eq("rst_fpu_regs", {fn1_a, fn2_a}, 64'h0);
        check_eq("rst_fpu_op_result", 64'({fop_a, res_a}), 64'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Single requester 0, add.
        drive_a(0, OP_A, OP_B, 2'b00);
        accept_a(0, c);
        check_eq("t1_ready_same_cycle", 64'(c), 64'd0);
        resp_wait_a(0, c);
        check_eq("t1_latency", 64'(c), 64'd4);
        check_eq("t1_result", 64'(res_a), 64'h7F0F5C29);
        check_eq("t1_gnt", 64'(gnt_a), 64'd0);
        @(posedge clk); #1;

        // Single requester 1, subtract; operands held through BUSY.
        drive_a(1, OP_A, OP_B, 2'b01);
        accept_a(1, c);
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (fn1_a !== OP_A || fn2_a !== OP_B || fop_a !== 2'b01 || !busy_a || rspv_a !== 2'b00)
                ok = 1'b0;
        end
        check_eq("t2_fpu_stable", 64'(ok), 64'h1);
        @(negedge clk);
        check_eq("t2_resp_valid", 64'(rspv_a), 64'h2);
        check_eq("t2_result", 64'(res_a), 64'h000CCCCD);
        check_eq("t2_gnt", 64'(gnt_a), 64'd1);
        @(posedge clk); #1;

        // Both requesters valid continuously from reset.
        rstn = 1'b0;
        drive_a(0, OP_A, OP_B, 2'b00);
        drive_a(1, 32'h12345678, 32'h00000111, 2'b01);
        @(negedge clk);
        check_eq("t3_ready_in_reset", 64'(rdy_a), 64'h0);
        exp_q_a.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            order[i] = -1;
            tm[i]    = -1;
        end
        n = 0;
        c = 0;
        while (n < 4 && c < 60) begin
            @(negedge clk);
            c++;
            if (rdy_a != 2'b00) begin
                check_eq("t3_ready_onehot", 64'($countones(rdy_a)), 64'd1);
                order[n] = int'(rdy_a[1]);
                tm[n]    = c;
                n++;
            end
        end
        check_eq("t3_grant_count", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++) check_eq("t3_grant_order", 64'(order[i]), 64'(i % 2));
        for (int i = 1; i < 4; i++) check_eq("t3_issue_interval", 64'(tm[i] - tm[i-1]), 64'd5);
        @(posedge clk); #1;
        rv_a = 2'b00;
        idle_a();

        // Back-pressure on requester 0 with requester 1 waiting.
        rr_a = 2'b10;
        drive_a(0, 32'h40000000, 32'h00000005, 2'b00);
        accept_a(0, c);
        drive_a(1, 32'h00000100, 32'h00000001, 2'b01);
        resp_wait_a(0, c);
        hold = res_a;
        ok   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rspv_a !== 2'b01 || res_a !== hold || rdy_a !== 2'b00) ok = 1'b0;
        end
        check_eq("t4_hold_stable", 64'(ok), 64'h1);
        check_eq("t4_hold_value", 64'(hold), 64'h40000005);
        @(posedge clk); #1;
        rr_a = 2'b11;
        accept_a(1, c);
        check_eq("t4_req1_after_release", 64'(c), 64'd1);
        resp_wait_a(1, c);
        @(posedge clk); #1;

        // Serve requester 0 so the pointer sits at 0, then abort a requester-1 op with reset.
        drive_a(0, 32'h00000005, 32'h00000006, 2'b00);
        accept_a(0, c);
        resp_wait_a(0, c);
        @(posedge clk); #1;
        drive_a(1, 32'h00000009, 32'h00000004, 2'b01);
        accept_a(1, c);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check_eq("t5_async_outs", 64'({rdy_a, rspv_a, busy_a, gnt_a, fop_a, dbg_a}), 64'h0);
        check_eq("t5_async_fpu", {fn1_a, fn2_a}, 64'h0);
        check_eq("t5_async_result", 64'(res_a), 64'h0);
        exp_q_a.delete();
        drive_a(0, 32'h00000010, 32'h00000020, 2'b00);
        drive_a(1, 32'h00000030, 32'h00000001, 2'b01);
        repeat (2) @(negedge clk);
        check_eq("t5_no_resp_in_reset", 64'(rspv_a), 64'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check_eq("t5_first_grant", 64'(rdy_a), 64'h1);
        @(posedge clk); #1;
        rv_a[0] = 1'b0;
        resp_wait_a(0, c);
        accept_a(1, c);
        resp_wait_a(1, c);
        @(posedge clk); #1;

        // Instance B: grant 2, then wrap to 0 ahead of 1.
        drive_b(2, OP_A, OP_B, 2'b00);
        accept_b(2, c);
        check_eq("t6_accept_req2", 64'(c), 64'd0);
        resp_wait_b(2, c);
        check_eq("t6_latency_req2", 64'(c), 64'd2);
        check_eq("t6_gnt_req2", 64'(gnt_b), 64'd2);
        @(posedge clk); #1;
        drive_b(0, 32'h00000007, 32'h00000003, 2'b01);
        drive_b(1, 32'h00000011, 32'h00000022, 2'b00);
        @(negedge clk);
        check_eq("t6_wrap_grant", 64'(rdy_b), 64'h1);
        @(posedge clk); #1;
        rv_b[0] = 1'b0;
        resp_wait_b(0, c);
        check_eq("t6_latency_req0", 64'(c), 64'd2);
        check_eq("t6_result_req0", 64'(res_b), 64'h4);
        accept_b(1, c);
        resp_wait_b(1, c);
        check_eq("t6_gnt_req1", 64'(gnt_b), 64'd1);
        @(posedge clk); #1;
        repeat (2) @(negedge clk);

        check_eq("a_sb_drained", 64'(exp_q_a.size()), 64'd0);
        check_eq("b_sb_drained", 64'(exp_q_b.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
